// File: rtl/juggle_pkg.sv
// Shared types and constants for the juggling pattern scheduler and its consumers.
package juggle_pkg;

    localparam int MAX_LEN   = 7;
    localparam int MAX_THROW = 7;
    localparam int NUM_SLOTS = 8;

    typedef logic [2:0] throw_t;
    typedef logic [2:0] ball_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    // One entry of the landing table: which ball lands on that beat, if any.
    typedef struct packed {
        logic     occupied;
        ball_id_t ball;
    } slot_t;

endpackage

// File: rtl/pattern_scheduler_beat_timer.sv
// Free-running beat counter: counts 0..CYCLES_PER_BEAT-1 while enabled and
// emits a tick whenever the count is 0. Also used by the display animation.
module beat_timer #(
    parameter int CYCLES_PER_BEAT = 32_500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (CYCLES_PER_BEAT > 1) ? $clog2(CYCLES_PER_BEAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BEAT - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise wrap at the last cycle of the beat.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled only on the clock edge here, so it sits inside the edge-triggered branch.
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && (count_q == '0);

endmodule

// File: rtl/pattern_scheduler.sv
// Steps through a validated siteswap one throw per beat, tracking individual
// balls through an 8-slot landing table indexed by beat number mod 8.
module pattern_scheduler
    import juggle_pkg::*;
#(
    parameter int CYCLES_PER_BEAT = 32_500_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  throw_t     pattern_in [MAX_LEN],
    input  logic [2:0] pattern_length,
    input  logic       pattern_valid_in,
    input  logic       start_in,
    input  logic       stop_in,
    output logic       running_out,
    output logic       beat_out,
    output throw_t     throw_out,
    output logic       hand_out,
    output ball_id_t   ball_out,
    output logic       ball_valid_out,
    output ball_id_t   ball_count_out,
    output logic       error_out
);

    sched_state_t state_q, state_d;
    throw_t       pattern_q [MAX_LEN];
    throw_t       pattern_d [MAX_LEN];
    logic [2:0]   len_q, len_d;
    logic [2:0]   idx_q, idx_d;
    logic [2:0]   beat_q, beat_d;
    ball_id_t     next_ball_q, next_ball_d;
    slot_t        slot_q [NUM_SLOTS];
    slot_t        slot_d [NUM_SLOTS];

    logic         beat_out_q, beat_out_d;
    throw_t       throw_q, throw_d;
    logic         hand_q, hand_d;
    ball_id_t     ball_q, ball_d;
    logic         ball_valid_q, ball_valid_d;
    logic         error_q, error_d;

    logic         tick;
    throw_t       cur_h;
    logic [2:0]   src, dst;
    ball_id_t     mover;

    // The counter is held at 0 outside RUN so the first RUN cycle is a beat.
    beat_timer #(
        .CYCLES_PER_BEAT(CYCLES_PER_BEAT)
    ) u_timer (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .clear_i ((state_q != RUN) || stop_in),
        .enable_i(state_q == RUN),
        .tick_o  (tick)
    );

    // Next-state logic: start handling in IDLE, stop and beat processing in RUN.
    always_comb begin
        state_d      = state_q;
        pattern_d    = pattern_q;
        len_d        = len_q;
        idx_d        = idx_q;
        beat_d       = beat_q;
        next_ball_d  = next_ball_q;
        slot_d       = slot_q;
        beat_out_d   = 1'b0;
        throw_d      = throw_q;
        hand_d       = hand_q;
        ball_d       = ball_q;
        ball_valid_d = ball_valid_q;
        error_d      = 1'b0;

        cur_h = pattern_q[idx_q];
        src   = beat_q;
        dst   = beat_q + cur_h;   // wraps mod 8 by width
        mover = slot_q[src].occupied ? slot_q[src].ball : next_ball_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (pattern_valid_in && (pattern_length != 3'd0)) begin
                        state_d     = RUN;
                        pattern_d   = pattern_in;
                        len_d       = pattern_length;
                        idx_d       = '0;
                        beat_d      = '0;
                        next_ball_d = '0;
                        for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (stop_in) begin
                    // ball count deliberately survives a stop until the next start
                    state_d      = IDLE;
                    throw_d      = '0;
                    hand_d       = 1'b0;
                    ball_d       = '0;
                    ball_valid_d = 1'b0;
                    for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = '0;
                end else if (tick) begin
                    if ((cur_h != '0) && slot_q[dst].occupied) begin
                        // Landing collision: abandon the pattern as if reset.
                        state_d      = IDLE;
                        error_d      = 1'b1;
                        idx_d        = '0;
                        beat_d       = '0;
                        next_ball_d  = '0;
                        throw_d      = '0;
                        hand_d       = 1'b0;
                        ball_d       = '0;
                        ball_valid_d = 1'b0;
                        for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = '0;
                    end else begin
                        beat_out_d  = 1'b1;
                        throw_d     = cur_h;
                        hand_d      = beat_q[0];
                        beat_d      = beat_q + 3'd1;
                        idx_d       = (idx_q == len_q - 3'd1) ? '0 : idx_q + 3'd1;
                        slot_d[src] = '0;
                        if (cur_h == '0) begin
                            ball_d       = '0;
                            ball_valid_d = 1'b0;
                        end else begin
                            ball_d       = mover;
                            ball_valid_d = 1'b1;
                            slot_d[dst]  = '{occupied: 1'b1, ball: mover};
                            if (!slot_q[src].occupied && (next_ball_q != 3'd7)) begin
                                next_ball_d = next_ball_q + 3'd1;
                            end
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, latched pattern, landing table and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            beat_q       <= '0;
            next_ball_q  <= '0;
            beat_out_q   <= 1'b0;
            throw_q      <= '0;
            hand_q       <= 1'b0;
            ball_q       <= '0;
            ball_valid_q <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) pattern_q[i] <= '0;
            // NOTE: the landing table must be reset; stale occupancy would fake collisions and ball ids.
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            // NOTE: non-blocking everywhere so every register samples the pre-edge values from the comb block.
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            beat_q       <= beat_d;
            next_ball_q  <= next_ball_d;
            slot_q       <= slot_d;
            beat_out_q   <= beat_out_d;
            throw_q      <= throw_d;
            hand_q       <= hand_d;
            ball_q       <= ball_d;
            ball_valid_q <= ball_valid_d;
            error_q      <= error_d;
        end
    end

    assign running_out    = (state_q == RUN);
    assign beat_out       = beat_out_q;
    assign throw_out      = throw_q;
    assign hand_out       = hand_q;
    assign ball_out       = ball_q;
    assign ball_valid_out = ball_valid_q;
    assign ball_count_out = next_ball_q;
    assign error_out      = error_q;

endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Downstream consumer of the siteswap validator: latches a validated pattern (throws 0..7, length 1..7) on start and steps through it one throw per beat.
- On each beat, emits the throw height, the hand (alternating), and the ball id being thrown.
- Ball ids come from an 8-slot landing table, so the juggler model and display can animate individual balls.

Parameters:
- CYCLES_PER_BEAT, 32_500_000, clock cycles between beats (0.5 s at 65 MHz); must be >= 2.
- MAX_LEN, 7, maximum pattern length.
- NUM_SLOTS, 8, landing-table depth; must exceed the maximum throw (7).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-low reset.
- pattern_in  input  7 x 3 (unpacked)  throw heights; entries at index >= pattern_length are ignored.
- pattern_length  input  3  number of throws, 1..7.
- pattern_valid_in  input  1  validator verdict for the current pattern_in/pattern_length.
- start_in  input  1  request to begin juggling.
- stop_in  input  1  request to halt.
- running_out  output  1  high while in RUN.
- beat_out  output  1  one-cycle pulse per beat.
- throw_out  output  3  throw height for this beat.
- hand_out  output  1  0 = right, 1 = left; first beat is right.
- ball_out  output  3  id of the thrown ball.
- ball_valid_out  output  1  high when the throw is nonzero.
- ball_count_out  output  3  number of distinct balls introduced so far.
- error_out  output  1  one-cycle pulse on a rejected start or a landing collision.

Behaviour:
- One clock. Reset is synchronous, active-low (rst_in == 0 at a clk_in edge).
- Reset: state IDLE; every output 0; all slots empty; beat counter, pattern index, cycle counter and next_ball all 0. A reset mid-RUN takes priority over everything and restores these values.
- States are IDLE and RUN only.
- IDLE:
  - start_in && pattern_valid_in && pattern_length != 0: latch pattern and length; clear all slots; clear next_ball, pattern index and beat counter; go to RUN.
  - start_in otherwise: error_out pulses for 1 cycle; stay in IDLE.
  - stop_in in IDLE has no effect.
- RUN:
  - The cycle counter counts 0..CYCLES_PER_BEAT-1 and wraps.
  - A beat fires on the first RUN cycle (counter == 0), i.e. 1 cycle after start is accepted, and then every CYCLES_PER_BEAT cycles.
  - Inputs are ignored except stop_in and rst_in. Changes to pattern_in have no effect until the next start.
- Beat processing, with h = latched[idx] and s = beat mod 8:
  - h == 0: ball_valid_out = 0, ball_out = 0, slot s is cleared.
  - h > 0: the ball is the slot s occupant if s is occupied. Otherwise the ball is next_ball, and next_ball increments, saturating at 7.
  - The ball is written to slot (s+h) mod 8, and slot s is cleared. Since h <= 7, these never alias.
  - If the target slot is already occupied: error_out pulses and the FSM returns to IDLE with reset-like clearing. This cannot happen for a valid pattern.
  - idx wraps from length-1 to 0. The beat counter is 3 bits and wraps mod 8. hand_out toggles every beat after the first.
- Outputs are registered:
  - throw_out, hand_out, ball_out and ball_valid_out update in the same cycle beat_out is high, and hold between beats.
  - ball_count_out always equals next_ball.
- stop_in in RUN: go to IDLE next edge. running_out, beat_out, throw_out, ball_out and ball_valid_out become 0. Slots are cleared. ball_count_out holds until the next start.
- Priority: rst_in > stop_in > beat processing. start_in is ignored in RUN.

Decomposition:
- Package juggle_pkg holds:
  - constants MAX_LEN = 7, MAX_THROW = 7, NUM_SLOTS = 8;
  - typedef throw_t (logic [2:0]);
  - typedef ball_id_t (logic [2:0]);
  - enum sched_state_t {IDLE, RUN}.
- Sub-module beat_timer: counter with clear and enable, emitting a tick when the count is 0. It is reusable by the display animation.

Test Plan:
- Reset: hold rst_in = 0 for 3 cycles with start_in = 1 -> all outputs 0, running_out = 0.
- "3", length 1, CYCLES_PER_BEAT = 4, valid: pulse start -> beat_out at cycles 1, 5, 9, ...; throw 3 each beat; balls 0,1,2,0,1,2; hands R,L,R,L; ball_count_out = 3.
- "531", length 3: first 7 beats -> throws 5,3,1,5,3,1,5; balls 0,1,2,2,1,0,0; ball_count_out = 3; no error_out.
- "40", length 2: beats -> ball_valid 1,0,1,0,1; balls 0,-,1,-,0; ball_count_out = 2.
- start_in with pattern_valid_in = 0 -> single-cycle error_out; running_out stays 0; no beat_out.
- stop_in mid-"531", then restart with "3" -> IDLE next cycle with outputs 0; after restart, balls restart 0,1,2 and ball_count_out counts from 0.
